// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the external interrupt arbiter: bus width, source ID
// width, register word offsets and gateway state encodings.
package irq_arbiter_pkg;

    localparam int DATA_BUS_WIDTH = 32;
    localparam int SRC_ID_WIDTH   = 4;

    // Register byte offsets on the core data bus
    localparam logic [7:0] IRQ_ARB_PRIO    = 8'h00;
    localparam logic [7:0] IRQ_ARB_ENABLE  = 8'h04;
    localparam logic [7:0] IRQ_ARB_PENDING = 8'h08;
    localparam logic [7:0] IRQ_ARB_THRESH  = 8'h0C;
    localparam logic [7:0] IRQ_ARB_CLAIM   = 8'h10;
    localparam logic [7:0] IRQ_ARB_TRIGGER = 8'h14;

    // Word indices as seen on address bits [4:2]
    localparam logic [2:0] IDX_PRIO    = IRQ_ARB_PRIO[4:2];
    localparam logic [2:0] IDX_ENABLE  = IRQ_ARB_ENABLE[4:2];
    localparam logic [2:0] IDX_PENDING = IRQ_ARB_PENDING[4:2];
    localparam logic [2:0] IDX_THRESH  = IRQ_ARB_THRESH[4:2];
    localparam logic [2:0] IDX_CLAIM   = IRQ_ARB_CLAIM[4:2];
    localparam logic [2:0] IDX_TRIGGER = IRQ_ARB_TRIGGER[4:2];

    // Per-source gateway states
    typedef enum logic [1:0] {
        GW_IDLE  = 2'd0,
        GW_PEND  = 2'd1,
        GW_INSVC = 2'd2
    } gw_state_e;

endpackage

// File: rtl/irq_gateway.sv
// One interrupt source: 2-flop synchronizer, rising-edge detector and the
// IDLE/PEND/INSVC gateway with a 1-deep edge_seen memory for edge mode.
module irq_gateway
    import irq_arbiter_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic src_i,
    input  logic trigger_i,
    input  logic claim_i,
    input  logic complete_i,
    output logic pend_o,
    output logic insvc_o
);

    logic      sync1_q, sync1_d;
    logic      sync2_q, sync2_d;
    logic      sync3_q, sync3_d;
    logic      edge_seen_q, edge_seen_d;
    gw_state_e state_q, state_d;
    logic      rise;
    logic      edge_rise;

    assign rise      = sync2_q & ~sync3_q;
    assign edge_rise = trigger_i & rise;

    // Synchronizer chain plus delayed copy for edge detection
    always_comb begin
        sync1_d = src_i;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    // Gateway next state; edge_seen only matters for edge-triggered sources
    // since a level source simply re-pends while still asserted
    always_comb begin
        state_d     = state_q;
        edge_seen_d = edge_seen_q;
        case (state_q)
            GW_IDLE: begin
                if (trigger_i ? rise : sync2_q) begin
                    state_d = GW_PEND;
                end
            end
            GW_PEND: begin
                if (claim_i) begin
                    state_d = GW_INSVC;
                    if (edge_rise) begin
                        edge_seen_d = 1'b1;
                    end
                end
            end
            GW_INSVC: begin
                if (edge_rise) begin
                    edge_seen_d = 1'b1;
                end
                if (complete_i) begin
                    state_d     = (edge_seen_q || edge_rise) ? GW_PEND : GW_IDLE;
                    edge_seen_d = 1'b0;
                end
            end
            default: begin
                state_d     = GW_IDLE;
                edge_seen_d = 1'b0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            edge_seen_q <= 1'b0;
            state_q     <= GW_IDLE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            edge_seen_q <= edge_seen_d;
            state_q     <= state_d;
        end
    end

    assign pend_o  = (state_q == GW_PEND);
    assign insvc_o = (state_q == GW_INSVC);

endmodule

// File: rtl/irq_arbiter.sv
// External interrupt arbiter: configuration registers, per-source gateways,
// priority selection, claim/complete handling and the single irq_o line.
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 8,
    parameter int PRIO_WIDTH = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_SRC-1:0]        src_irq_i,
    input  logic                      reg_we_i,
    input  logic                      reg_re_i,
    input  logic [7:0]                reg_addr_i,
    input  logic [DATA_BUS_WIDTH-1:0] reg_wdata_i,
    output logic [DATA_BUS_WIDTH-1:0] reg_rdata_o,
    output logic                      reg_rdata_vld_o,
    output logic                      irq_o
);

    logic [NUM_SRC-1:0][PRIO_WIDTH-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0]                 enable_q, enable_d;
    logic [NUM_SRC-1:0]                 trigger_q, trigger_d;
    logic [PRIO_WIDTH-1:0]              thresh_q, thresh_d;
    logic [SRC_ID_WIDTH-1:0]            best_id_q, best_id_d;
    logic                               irq_q, irq_d;
    logic [DATA_BUS_WIDTH-1:0]          rdata_q, rdata_d;
    logic                               rdata_vld_q, rdata_vld_d;

    logic [NUM_SRC-1:0]                 pend, insvc, eligible;
    logic [NUM_SRC-1:0]                 claim_vec, complete_vec;
    logic [PRIO_WIDTH-1:0]              best_prio;
    logic [2:0]                         word_idx;
    logic                               rd_en;
    logic [SRC_ID_WIDTH-1:0]            complete_id;
    logic                               unused_bits;

    assign word_idx    = reg_addr_i[4:2];
    assign rd_en       = reg_re_i & ~reg_we_i;
    assign complete_id = reg_wdata_i[SRC_ID_WIDTH-1:0];
    assign unused_bits = ^{reg_addr_i[7:5], reg_addr_i[1:0], reg_wdata_i};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        irq_gateway u_gateway (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .src_i      (src_irq_i[i]),
            .trigger_i  (trigger_q[i]),
            .claim_i    (claim_vec[i]),
            .complete_i (complete_vec[i]),
            .pend_o     (pend[i]),
            .insvc_o    (insvc[i])
        );
    end

    // Claim goes to the registered winner; complete to the ID in write data
    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rd_en && word_idx == IDX_CLAIM && best_id_q == SRC_ID_WIDTH'(i + 1)) begin
                claim_vec[i] = 1'b1;
            end
            if (reg_we_i && word_idx == IDX_CLAIM && complete_id == SRC_ID_WIDTH'(i + 1)) begin
                complete_vec[i] = 1'b1;
            end
        end
    end

    // Configuration register writes
    always_comb begin
        prio_d    = prio_q;
        enable_d  = enable_q;
        thresh_d  = thresh_q;
        trigger_d = trigger_q;
        if (reg_we_i) begin
            case (word_idx)
                IDX_PRIO: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        prio_d[i] = reg_wdata_i[4*i +: PRIO_WIDTH];
                    end
                end
                IDX_ENABLE:  enable_d  = reg_wdata_i[NUM_SRC-1:0];
                IDX_THRESH:  thresh_d  = reg_wdata_i[PRIO_WIDTH-1:0];
                IDX_TRIGGER: trigger_d = reg_wdata_i[NUM_SRC-1:0];
                default: ;
            endcase
        end
    end

    // Read mux; a read colliding with a write returns zero
    always_comb begin
        rdata_d     = '0;
        rdata_vld_d = reg_re_i;
        if (rd_en) begin
            case (word_idx)
                IDX_PRIO: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        rdata_d[4*i +: PRIO_WIDTH] = prio_q[i];
                    end
                end
                IDX_ENABLE:  rdata_d[NUM_SRC-1:0]      = enable_q;
                IDX_PENDING: rdata_d[NUM_SRC-1:0]      = pend;
                IDX_THRESH:  rdata_d[PRIO_WIDTH-1:0]   = thresh_q;
                IDX_CLAIM:   rdata_d[SRC_ID_WIDTH-1:0] = best_id_q;
                IDX_TRIGGER: rdata_d[NUM_SRC-1:0]      = trigger_q;
                default: ;
            endcase
        end
    end

    // Priority selection; strict compare keeps the lowest index on a tie
    always_comb begin
        best_prio = '0;
        best_id_d = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = pend[i] & enable_q[i] & (prio_q[i] > thresh_q);
            if (eligible[i] && prio_q[i] > best_prio) begin
                best_prio = prio_q[i];
                best_id_d = SRC_ID_WIDTH'(i + 1);
            end
        end
        irq_d = (|eligible) & ~(|insvc);
    end

    // Register file and output registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_q      <= '0;
            enable_q    <= '0;
            thresh_q    <= '0;
            trigger_q   <= '0;
            best_id_q   <= '0;
            irq_q       <= 1'b0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            enable_q    <= enable_d;
            thresh_q    <= thresh_d;
            trigger_q   <= trigger_d;
            best_id_q   <= best_id_d;
            irq_q       <= irq_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
        end
    end

    assign reg_rdata_o     = rdata_q;
    assign reg_rdata_vld_o = rdata_vld_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed testbench for irq_arbiter with hand-computed expectations.
module tb_irq_arbiter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  src_irq;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rdata_vld;
    logic        irq;

    int num_checks = 0;
    int num_fail   = 0;

    localparam logic [7:0] A_PRIO    = 8'h00;
    localparam logic [7:0] A_ENABLE  = 8'h04;
    localparam logic [7:0] A_PENDING = 8'h08;
    localparam logic [7:0] A_THRESH  = 8'h0C;
    localparam logic [7:0] A_CLAIM   = 8'h10;
    localparam logic [7:0] A_TRIGGER = 8'h14;

    irq_arbiter #(.NUM_SRC(8), .PRIO_WIDTH(3)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .src_irq_i       (src_irq),
        .reg_we_i        (reg_we),
        .reg_re_i        (reg_re),
        .reg_addr_i      (reg_addr),
        .reg_wdata_i     (reg_wdata),
        .reg_rdata_o     (reg_rdata),
        .reg_rdata_vld_o (reg_rdata_vld),
        .irq_o           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle bus strobe; returns at the negedge after the accepting edge
    task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr,
                                 input logic [31:0] wdata);
        @(negedge clk);
        reg_we    = we;
        reg_re    = re;
        reg_addr  = addr;
        reg_wdata = wdata;
        @(negedge clk);
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reg_addr  = 8'h00;
        reg_wdata = 32'h0;
    endtask

    task automatic writeReg(input logic [7:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, 1'b0, addr, wdata);
    endtask

    task automatic readExpect(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        applyStimulus(1'b0, 1'b1, addr, 32'h0);
        checkOutput(tag, reg_rdata, exp);
        checkOutput({tag, "_vld"}, {31'h0, reg_rdata_vld}, 32'h1);
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        src_irq   = 8'h00;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reg_addr  = 8'h00;
        reg_wdata = 32'h0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        checkOutput("rst_rdata", reg_rdata, 32'h0);
        checkOutput("rst_vld", {31'h0, reg_rdata_vld}, 32'h0);
    endtask

    initial begin
        $display("[TB] irq_arbiter directed test start");

        // Reset state
        doReset();
        readExpect("rst_pending", A_PENDING, 32'h0);
        readExpect("rst_prio", A_PRIO, 32'h0);

        // Level path with exact latency
        writeReg(A_PRIO, 32'h0000_0005);
        writeReg(A_ENABLE, 32'h01);
        writeReg(A_THRESH, 32'h0);
        src_irq[0] = 1'b1;
        waitCycles(3);
        checkOutput("lvl_irq_n2", {31'h0, irq}, 32'h0);
        waitCycles(1);
        checkOutput("lvl_irq_n3", {31'h0, irq}, 32'h1);
        readExpect("lvl_claim", A_CLAIM, 32'h1);
        waitCycles(1);
        checkOutput("lvl_irq_after_claim", {31'h0, irq}, 32'h0);
        checkOutput("lvl_vld_pulse", {31'h0, reg_rdata_vld}, 32'h0);
        writeReg(A_CLAIM, 32'h1);
        waitCycles(1);
        checkOutput("lvl_irq_m1", {31'h0, irq}, 32'h0);
        waitCycles(1);
        checkOutput("lvl_irq_m2", {31'h0, irq}, 32'h1);
        readExpect("lvl_claim2", A_CLAIM, 32'h1);
        src_irq[0] = 1'b0;
        waitCycles(3);
        writeReg(A_CLAIM, 32'h1);
        waitCycles(3);
        readExpect("lvl_pending_clear", A_PENDING, 32'h0);
        checkOutput("lvl_irq_idle", {31'h0, irq}, 32'h0);

        // Arbitration: idx2/idx5 at prio 3, idx4 at prio 6
        doReset();
        writeReg(A_PRIO, 32'h0036_0300);
        writeReg(A_ENABLE, 32'h34);
        src_irq = 8'h34;
        waitCycles(5);
        checkOutput("arb_irq", {31'h0, irq}, 32'h1);
        readExpect("arb_claim_a", A_CLAIM, 32'h5);
        src_irq[4] = 1'b0;
        waitCycles(3);
        writeReg(A_CLAIM, 32'h5);
        waitCycles(4);
        checkOutput("arb_irq_b", {31'h0, irq}, 32'h1);
        readExpect("arb_claim_b", A_CLAIM, 32'h3);
        src_irq[2] = 1'b0;
        waitCycles(3);
        writeReg(A_CLAIM, 32'h3);
        waitCycles(4);
        readExpect("arb_claim_c", A_CLAIM, 32'h6);
        src_irq[5] = 1'b0;
        waitCycles(3);
        writeReg(A_CLAIM, 32'h6);
        waitCycles(4);
        checkOutput("arb_irq_done", {31'h0, irq}, 32'h0);

        // Threshold and enable masking
        doReset();
        writeReg(A_PRIO, 32'h2);
        writeReg(A_ENABLE, 32'h1);
        writeReg(A_THRESH, 32'h2);
        src_irq[0] = 1'b1;
        waitCycles(5);
        checkOutput("thr_irq_blocked", {31'h0, irq}, 32'h0);
        readExpect("thr_pending", A_PENDING, 32'h1);
        writeReg(A_THRESH, 32'h1);
        waitCycles(3);
        checkOutput("thr_irq_open", {31'h0, irq}, 32'h1);
        writeReg(A_ENABLE, 32'h0);
        waitCycles(3);
        checkOutput("thr_irq_masked", {31'h0, irq}, 32'h0);
        readExpect("thr_pending_masked", A_PENDING, 32'h1);

        // Edge mode with an edge captured during service
        doReset();
        writeReg(A_PRIO, 32'h40);
        writeReg(A_ENABLE, 32'h2);
        writeReg(A_TRIGGER, 32'h2);
        readExpect("edge_trigger_rd", A_TRIGGER, 32'h2);
        src_irq[1] = 1'b1;
        waitCycles(2);
        src_irq[1] = 1'b0;
        waitCycles(5);
        checkOutput("edge_irq", {31'h0, irq}, 32'h1);
        readExpect("edge_claim", A_CLAIM, 32'h2);
        src_irq[1] = 1'b1;
        waitCycles(2);
        src_irq[1] = 1'b0;
        waitCycles(5);
        checkOutput("edge_irq_insvc", {31'h0, irq}, 32'h0);
        readExpect("edge_pending_insvc", A_PENDING, 32'h0);
        writeReg(A_CLAIM, 32'h7);
        waitCycles(3);
        checkOutput("edge_bogus_irq", {31'h0, irq}, 32'h0);
        readExpect("edge_bogus_pending", A_PENDING, 32'h0);
        writeReg(A_CLAIM, 32'h2);
        waitCycles(3);
        checkOutput("edge_repend_irq", {31'h0, irq}, 32'h1);
        readExpect("edge_repend_pending", A_PENDING, 32'h2);
        readExpect("edge_claim2", A_CLAIM, 32'h2);
        writeReg(A_CLAIM, 32'h2);
        waitCycles(3);
        readExpect("edge_idle_pending", A_PENDING, 32'h0);
        checkOutput("edge_idle_irq", {31'h0, irq}, 32'h0);

        // Corner cases
        doReset();
        readExpect("corner_empty_claim", A_CLAIM, 32'h0);
        checkOutput("corner_empty_irq", {31'h0, irq}, 32'h0);
        applyStimulus(1'b1, 1'b1, A_ENABLE, 32'hFF);
        checkOutput("corner_rw_rdata", reg_rdata, 32'h0);
        checkOutput("corner_rw_vld", {31'h0, reg_rdata_vld}, 32'h1);
        readExpect("corner_rw_enable", A_ENABLE, 32'hFF);
        writeReg(8'h1C, 32'hFFFF_FFFF);
        readExpect("corner_unmapped", 8'h18, 32'h0);
        writeReg(A_PRIO, 32'hFFFF_FFFF);
        readExpect("corner_prio_mask", A_PRIO, 32'h7777_7777);
        writeReg(A_PENDING, 32'hFF);
        readExpect("corner_pending_ro", A_PENDING, 32'h0);

        // Asynchronous reset while a source is in service
        doReset();
        writeReg(A_PRIO, 32'h5);
        writeReg(A_ENABLE, 32'h1);
        src_irq[0] = 1'b1;
        waitCycles(5);
        readExpect("rsvc_claim", A_CLAIM, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rsvc_irq", {31'h0, irq}, 32'h0);
        checkOutput("rsvc_rdata", reg_rdata, 32'h0);
        checkOutput("rsvc_vld", {31'h0, reg_rdata_vld}, 32'h0);
        src_irq = 8'h00;
        waitCycles(3);
        rst_n = 1'b1;
        waitCycles(3);
        readExpect("rsvc_pending", A_PENDING, 32'h0);
        readExpect("rsvc_enable", A_ENABLE, 32'h0);
        checkOutput("rsvc_irq_after", {31'h0, irq}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Platform-level external interrupt arbiter between up to eight peripheral interrupt lines and the single `irq_i` input of the core interrupt controller. It synchronizes each source and runs a per-source pending/in-service gateway. It selects the highest-priority eligible source and raises one interrupt line, which drops again after claim so the downstream rising-edge detector sees one edge per interrupt. Software configures it and performs claim/complete through a small word-addressed register port on the core data bus.

## Interface
- `NUM_SRC`, 8: number of sources, legal 1..8; source index i has ID i+1, ID 0 = none.
- `PRIO_WIDTH`, 3: priority field width, legal 1..4.
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `src_irq_i` in NUM_SRC: raw peripheral interrupt lines, asynchronous to `clk_i`.
- `reg_we_i` in 1: register write strobe, one cycle.
- `reg_re_i` in 1: register read strobe, one cycle.
- `reg_addr_i` in 8: byte address, word aligned; bits [4:2] decoded.
- `reg_wdata_i` in `DATA_BUS_WIDTH`: write data.
- `reg_rdata_o` out `DATA_BUS_WIDTH`: read data, registered.
- `reg_rdata_vld_o` out 1: read data valid, one-cycle pulse.
- `irq_o` out 1: registered interrupt request to the core interrupt controller `irq_i`.

## Operation
- Register map:
  - 0x00 PRIO: source i priority at bits [4i+PRIO_WIDTH-1:4i]; other bits read 0.
  - 0x04 ENABLE: bit i.
  - 0x08 PENDING: read-only; writes ignored.
  - 0x0C THRESHOLD: [PRIO_WIDTH-1:0].
  - 0x10 CLAIM (read) / COMPLETE (write).
  - 0x14 TRIGGER: bit i, 1 = rising edge, 0 = level.
  - Unmapped addresses read 0; writes to them are ignored.
- Synchronizer: each source passes through a 2-flop synchronizer; edge detection uses synced stage 2 against its delayed copy.
- Gateway per source, states IDLE, PEND, INSVC:
  - IDLE→PEND: level mode while the synced level is 1; edge mode on a synced rising edge.
  - PEND→INSVC: on a claim returning this ID.
  - INSVC→IDLE: on a COMPLETE write whose `reg_wdata_i[3:0]` equals this ID.
  - An edge arriving in INSVC sets a 1-deep `edge_seen` flag. On complete, a set `edge_seen` forces PEND instead of IDLE and clears the flag.
  - Further edges while in PEND are merged.
- Eligibility: pending & enable & (prio > threshold). Priority 0 never fires. Disabling a pending source masks it; it stays pending.
- Selection: highest priority wins; a tie goes to the lowest index. The result is registered as `best_id_q` every cycle.
- No nesting: `irq_o` is registered as (any eligible) & ~(any source INSVC).
- CLAIM read: returns `best_id_q` (0 if none) and moves that source to INSVC. It has no side effect when the result is 0.
- COMPLETE write: ignored when the ID is 0, greater than NUM_SRC, or not in INSVC.
- `reg_we_i` and `reg_re_i` in the same cycle: the write is performed; the read returns 0 with `reg_rdata_vld_o` high and has no side effect.

## Timing
- Reset values, all 0: every output, PRIO, ENABLE, THRESHOLD, TRIGGER, all gateway states (IDLE), `edge_seen`, synchronizers, and `best_id_q`.
- Source latency: `src_irq_i` sampled high at edge N gives synced stage 2 at N+1, PEND at N+2, and `best_id_q`/`irq_o` at N+3.
- Read strobe accepted at edge M: `reg_rdata_o`/`reg_rdata_vld_o` valid for the cycle after M. A claim moves the gateway to INSVC at M. `irq_o` is low from M+1.
- Register writes take effect at the accepting edge; eligibility reflects them one edge later.
- Complete at edge M with a level source still high: PEND at M+1, and `irq_o` rises at M+2. This guarantees at least one low cycle on `irq_o` between interrupts.
- Claim on the same edge as a new edge on the claimed source: `edge_seen` is set.
- An asynchronous reset mid-service clears INSVC and all pending state. A source held high across reset release goes PEND two edges after release.

## Structure
- Shared `chip_param.v` gains:
  - register offset constants `IRQ_ARB_PRIO`, `IRQ_ARB_ENABLE`, `IRQ_ARB_PENDING`, `IRQ_ARB_THRESH`, `IRQ_ARB_CLAIM`, `IRQ_ARB_TRIGGER`;
  - source-ID width 4;
  - gateway state encodings.
- Sub-module `irq_gateway`: one source's synchronizer, edge detector, IDLE/PEND/INSVC FSM, and `edge_seen`; instantiated NUM_SRC times.
- The top level holds the registers, the priority selector, the claim/complete decode and `irq_o`.

## Test plan
- Level path: PRIO=0x0000_0005, ENABLE=0x01, THRESHOLD=0, `src_irq_i[0]`=1 → `irq_o`=1 at N+3. CLAIM reads 1 and `irq_o` drops. Write COMPLETE=1 with the source still high → `irq_o` rises again two edges later.
- Arbitration: sources 2 and 5 at prio 3, source 4 at prio 6, all pending and enabled → claims return 5, then 3, then 6 (each after a complete).
- Threshold/mask: prio 2, THRESHOLD=2 → `irq_o` stays 0. Set THRESHOLD=1 → `irq_o` goes to 1. Clear ENABLE → PENDING still reads the bit and `irq_o` goes to 0.
- Edge mode: TRIGGER bit 1 set, pulse `src_irq_i[1]` during INSVC → after COMPLETE=2 the source is re-pended and the next claim returns 2. A bogus COMPLETE=7 is ignored.
- Corner cases: with nothing pending, CLAIM reads 0 with no effect. Simultaneous read/write to 0x04 → write applied and read returns 0. Reset asserted mid-INSVC → all outputs 0 and PENDING=0.
